top_varint_deser: RTL and testbench
===================================

Name: top_varint_deser

Overview:
- Streaming protobuf varint decoder; the inverse of the varint serializer path.
- Accepts one encoded byte per cycle and reassembles the 64-bit value.
- Applies zigzag decode for sint32 (field_type 17) and sint64 (field_type 18).
- Sits between the byte-stream parser front end and the field-value consumer; presents one decoded word at a time on a valid/ready output.

Parameters:
- MAX_BYTES, 10, maximum encoded length accepted; reaching it terminates the word.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  in_byte is valid
- in_byte  input  8  encoded byte; bit7 = continuation, bits6:0 = payload
- in_ready  output  1  decoder accepts in_byte this cycle
- field_type  input  5  protobuf field type; sampled with the first byte of each varint
- out_valid  output  1  decoded word is held on out_value
- out_ready  input  1  consumer accepts the word
- out_value  output  64  decoded value (zigzag-decoded when applicable)
- out_len  output  4  number of encoded bytes consumed, 1..10
- out_err  output  1  word terminated abnormally (overlong)

Behaviour:
- Reset (async, rst_n=0):
  - out_valid=0, out_value=0, out_len=0, out_err=0.
  - Accumulator=0, byte index=0, state=IDLE.
  - in_ready is 1 after reset.
  - A reset mid-word discards the partial word; no output is produced for it.
- Handshake:
  - Input transfer when in_valid & in_ready.
  - Output transfer when out_valid & out_ready.
  - in_ready = !out_valid | out_ready (single output register, 1 byte/cycle sustained).
- States:
  - IDLE (byte index 0), ACCUM (index 1..9). out_valid is a separate flag.
  - IDLE + transfer: latch field_type; acc = {57'b0, in_byte[6:0]}; idx=1.
    - in_byte[7]=0 completes the word.
    - Otherwise go to ACCUM.
  - ACCUM + transfer: acc |= in_byte[6:0] << 7*idx (bits above 63 dropped); idx++.
    - in_byte[7]=0 completes the word.
    - idx reaching MAX_BYTES with in_byte[7]=1 also completes the word, with err=1.
  - On completion:
    - Next edge: out_valid=1, out_value=decode(acc), out_len=idx, out_err=err.
    - Return to IDLE with acc=0, idx=0.
  - A completing byte accepted in the same cycle as an output transfer replaces the held word; out_valid stays 1.
  - Output transfer with no completion clears out_valid. out_value, out_len and out_err hold their last values.
- Latency: out_valid rises the cycle after the terminating byte is accepted.
- Decode:
  - field_type 18: out = (acc >> 1) ^ -(acc[0]) over 64 bits.
  - field_type 17: 32-bit zigzag decode on acc[31:0], then sign-extended to 64 bits; acc[63:32] ignored.
  - All other types: out = acc unchanged.
- 10th byte: only bit0 of the payload lands in bit 63; bits 6:1 are discarded.
- in_valid while in_ready=0: byte is not consumed; state unchanged.
- field_type changes mid-word are ignored.

Optional Feature:
- Macro: VARINT_DESER_STRICT_EN.
- Defined:
  - A 10th byte with any of payload bits 6:1 nonzero sets out_err=1.
  - For field_type 17, any nonzero acc[63:32] sets out_err=1.
  - Value is still emitted, decoded as usual.
- Undefined: those bits are silently truncated; out_err is raised only for overlong (continuation set on the 10th byte).

Test Plan:
- Single byte 0x01, field_type 5, out_ready=1 -> out_value=1, out_len=1, out_err=0, out_valid one cycle after the byte.
- Bytes 0xAC,0x02, field_type 3 -> out_value=300, out_len=2.
- sint64 (type 18) byte 0x03 -> out_value=0xFFFFFFFFFFFFFFFE (-2).
- sint32 (type 17) bytes 0xFE,0xFF,0xFF,0xFF,0x0F -> out_value=0x000000007FFFFFFF, out_len=5.
- Ten bytes 0xFF×9,0x01 -> out_value=0xFFFFFFFFFFFFFFFF, out_len=10, err=0.
- Ten bytes of 0xFF -> out_err=1, out_len=10; next byte 0x05 decodes to 5.
- Backpressure: out_ready=0 while two varints stream -> in_ready drops after the first completes; second word emitted intact after out_ready=1.
- rst_n pulsed low between bytes 0xAC and 0x02 -> no output; the next byte 0x02 decodes to 2.

Source files
------------

// File: rtl/top_varint_deser.sv
// rtl/top_varint_deser.sv - streaming protobuf varint decoder, one byte per cycle, zigzag for sint32/sint64
// Optional: define VARINT_DESER_STRICT_EN to flag truncated 10th-byte payload and sint32 high bits in out_err.
module top_varint_deser #(
  parameter int MAX_BYTES = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [7:0]  in_byte,
  output logic        in_ready,
  input  logic [4:0]  field_type,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_value,
  output logic [3:0]  out_len,
  output logic        out_err
);
  typedef enum logic {IDLE, ACCUM} state_t;

  localparam logic [3:0] MAX_IDX   = 4'(MAX_BYTES);
  localparam logic [4:0] FT_SINT32 = 5'd17;
  localparam logic [4:0] FT_SINT64 = 5'd18;

  state_t      state_q, state_d;
  logic [63:0] acc_q, acc_d;
  logic [3:0]  idx_q, idx_d;
  logic [4:0]  ftype_q, ftype_d;
  logic        out_valid_d;
  logic [63:0] out_value_d;
  logic [3:0]  out_len_d;
  logic        out_err_d;

  logic        xfer;
  logic [4:0]  ftype_eff;
  logic [3:0]  idx_inc;
  logic [6:0]  shamt;
  logic [63:0] acc_new;
  logic        last_byte;
  logic        err_new;

  function automatic logic [63:0] decode(input logic [63:0] a, input logic [4:0] ft);
    logic [31:0] z;
    z = {1'b0, a[31:1]} ^ {32{a[0]}};
    if (ft == FT_SINT64)
      decode = {1'b0, a[63:1]} ^ {64{a[0]}};
    else if (ft == FT_SINT32)
      decode = {{32{z[31]}}, z};
    else
      decode = a;
  endfunction

  assign in_ready = !out_valid | out_ready;

  always_comb begin
    xfer      = in_valid & in_ready;
    // field_type is only honoured on the first byte; later bytes use the latched copy
    ftype_eff = (state_q == IDLE) ? field_type : ftype_q;
    idx_inc   = idx_q + 4'd1;
    shamt     = 7'(idx_q) * 7'd7;
    // payload bits shifted past bit 63 fall off the 64-bit result
    acc_new   = acc_q | ({57'b0, in_byte[6:0]} << shamt);
    last_byte = !in_byte[7] || (idx_inc == MAX_IDX);
    err_new   = in_byte[7] && (idx_inc == MAX_IDX);
`ifdef VARINT_DESER_STRICT_EN
    if ((idx_inc == 4'd10) && (in_byte[6:1] != 6'd0))
      err_new = 1'b1;
    if ((ftype_eff == FT_SINT32) && (acc_new[63:32] != 32'd0))
      err_new = 1'b1;
`endif

    state_d     = state_q;
    acc_d       = acc_q;
    idx_d       = idx_q;
    ftype_d     = ftype_q;
    out_valid_d = out_valid;
    out_value_d = out_value;
    out_len_d   = out_len;
    out_err_d   = out_err;

    if (out_valid && out_ready)
      out_valid_d = 1'b0;

    if (xfer) begin
      if (state_q == IDLE)
        ftype_d = field_type;
      if (last_byte) begin
        state_d     = IDLE;
        acc_d       = 64'd0;
        idx_d       = 4'd0;
        out_valid_d = 1'b1;
        out_value_d = decode(acc_new, ftype_eff);
        out_len_d   = idx_inc;
        out_err_d   = err_new;
      end else begin
        state_d = ACCUM;
        acc_d   = acc_new;
        idx_d   = idx_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      acc_q     <= 64'd0;
      idx_q     <= 4'd0;
      ftype_q   <= 5'd0;
      out_valid <= 1'b0;
      out_value <= 64'd0;
      out_len   <= 4'd0;
      out_err   <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      idx_q     <= idx_d;
      ftype_q   <= ftype_d;
      out_valid <= out_valid_d;
      out_value <= out_value_d;
      out_len   <= out_len_d;
      out_err   <= out_err_d;
    end
  end
endmodule

// File: tb/tb_top_varint_deser.sv
// tb/tb_top_varint_deser.sv - directed table-driven bench for top_varint_deser
module tb_top_varint_deser;
  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  in_byte;
  logic        in_ready;
  logic [4:0]  field_type;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_value;
  logic [3:0]  out_len;
  logic        out_err;

`ifdef VARINT_DESER_STRICT_EN
  localparam logic STRICT = 1'b1;
`else
  localparam logic STRICT = 1'b0;
`endif

  top_varint_deser #(.MAX_BYTES(10)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_byte(in_byte), .in_ready(in_ready),
    .field_type(field_type),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_value(out_value), .out_len(out_len), .out_err(out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  ft;
    logic [3:0]  n;
    logic [79:0] b;
    logic [63:0] val;
    logic [3:0]  len;
    logic        err;
  } vec_t;

  vec_t vecs [11];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // present one byte and hold it until accepted on a rising edge
  task automatic send(input logic [7:0] b, input logic [4:0] ft);
    int n;
    n = 0;
    in_valid   = 1'b1;
    in_byte    = b;
    field_type = ft;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) check("send_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{ft:5'd5,  n:4'd1,  b:80'h01, val:64'd1, len:4'd1, err:1'b0};
    vecs[1]  = '{ft:5'd3,  n:4'd2,  b:80'h02AC, val:64'd300, len:4'd2, err:1'b0};
    vecs[2]  = '{ft:5'd18, n:4'd1,  b:80'h03, val:64'hFFFF_FFFF_FFFF_FFFE, len:4'd1, err:1'b0};
    vecs[3]  = '{ft:5'd17, n:4'd5,  b:80'h0F_FFFF_FFFE, val:64'h0000_0000_7FFF_FFFF, len:4'd5, err:1'b0};
    vecs[4]  = '{ft:5'd0,  n:4'd10, b:80'h01_FFFF_FFFF_FFFF_FFFF_FF, val:64'hFFFF_FFFF_FFFF_FFFF, len:4'd10, err:1'b0};
    vecs[5]  = '{ft:5'd0,  n:4'd10, b:80'hFFFF_FFFF_FFFF_FFFF_FFFF, val:64'hFFFF_FFFF_FFFF_FFFF, len:4'd10, err:1'b1};
    vecs[6]  = '{ft:5'd0,  n:4'd1,  b:80'h05, val:64'd5, len:4'd1, err:1'b0};
    vecs[7]  = '{ft:5'd17, n:4'd1,  b:80'h03, val:64'hFFFF_FFFF_FFFF_FFFE, len:4'd1, err:1'b0};
    vecs[8]  = '{ft:5'd18, n:4'd1,  b:80'h04, val:64'd2, len:4'd1, err:1'b0};
    vecs[9]  = '{ft:5'd17, n:4'd6,  b:80'h01_8080_8080_80, val:64'd0, len:4'd6, err:STRICT};
    vecs[10] = '{ft:5'd1,  n:4'd10, b:80'h02_FFFF_FFFF_FFFF_FFFF_FF, val:64'h7FFF_FFFF_FFFF_FFFF, len:4'd10, err:STRICT};

    rst_n = 1'b0; in_valid = 1'b0; in_byte = 8'h00; field_type = 5'd0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_value", out_value, 64'd0);
    check("rst_out_len",   {60'd0, out_len}, 64'd0);
    check("rst_out_err",   {63'd0, out_err}, 64'd0);
    check("rst_in_ready",  {63'd0, in_ready}, 64'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // back-to-back vectors: later bytes carry a different field_type that must be ignored
    for (int i = 0; i < 11; i++) begin
      for (int j = 0; j < int'(vecs[i].n); j++)
        send(vecs[i].b[8*j +: 8], (j == 0) ? vecs[i].ft : ~vecs[i].ft);
      check($sformatf("v%0d_valid", i), {63'd0, out_valid}, 64'd1);
      check($sformatf("v%0d_value", i), out_value, vecs[i].val);
      check($sformatf("v%0d_len", i),   {60'd0, out_len}, {60'd0, vecs[i].len});
      check($sformatf("v%0d_err", i),   {63'd0, out_err}, {63'd0, vecs[i].err});
    end
    @(posedge clk); #1;
    check("drain_valid", {63'd0, out_valid}, 64'd0);
    check("drain_hold_value", out_value, 64'h7FFF_FFFF_FFFF_FFFF);

    // backpressure: first word held, second varint stalls until out_ready
    out_ready = 1'b0;
    send(8'h05, 5'd0);
    check("bp_valid", {63'd0, out_valid}, 64'd1);
    check("bp_in_ready", {63'd0, in_ready}, 64'd0);
    in_valid = 1'b1; in_byte = 8'hAC; field_type = 5'd0;
    repeat (3) @(posedge clk);
    #1;
    check("bp_hold_value", out_value, 64'd5);
    check("bp_hold_len", {60'd0, out_len}, 64'd1);
    check("bp_still_valid", {63'd0, out_valid}, 64'd1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_released", {63'd0, out_valid}, 64'd0);
    send(8'h02, 5'd7);
    check("bp2_valid", {63'd0, out_valid}, 64'd1);
    check("bp2_value", out_value, 64'd300);
    check("bp2_len", {60'd0, out_len}, 64'd2);
    @(posedge clk); #1;

    // reset between bytes discards the partial word
    send(8'hAC, 5'd0);
    check("mid_no_valid", {63'd0, out_valid}, 64'd0);
    rst_n = 1'b0;
    #3;
    check("mid_rst_len", {60'd0, out_len}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("mid_after_valid", {63'd0, out_valid}, 64'd0);
    send(8'h02, 5'd0);
    check("mid_value", out_value, 64'd2);
    check("mid_len", {60'd0, out_len}, 64'd1);
    check("mid_err", {63'd0, out_err}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
